// File: rtl/multicycle_ctrl_fsm_if.sv
// Signal bundle between the multi-cycle sequencer and the datapath / shared memory port.
// master = the sequencer, slave = the datapath/memory side that feeds it.
interface multicycle_ctrl_fsm_if #(
    parameter int INSTRET_W = 32
);
    logic                 run_i;
    logic [6:0]           opcode_i;
    logic [2:0]           funct3_i;
    logic                 mem_ready_i;
    logic                 alu_zero_i;
    logic                 mem_req_o;
    logic                 mem_we_o;
    logic                 iord_o;
    logic                 ir_write_o;
    logic                 mdr_write_o;
    logic                 rf_latch_o;
    logic                 pc_write_o;
    logic                 pc_src_o;
    logic [1:0]           alu_src_a_o;
    logic [1:0]           alu_src_b_o;
    logic [1:0]           alu_op_sel_o;
    logic                 reg_write_o;
    logic                 wb_sel_o;
    logic                 trap_o;
    logic [1:0]           trap_cause_o;
    logic [INSTRET_W-1:0] instret_o;
    logic [3:0]           state_o;

    modport master (
        input  run_i, opcode_i, funct3_i, mem_ready_i, alu_zero_i,
        output mem_req_o, mem_we_o, iord_o, ir_write_o, mdr_write_o, rf_latch_o,
               pc_write_o, pc_src_o, alu_src_a_o, alu_src_b_o, alu_op_sel_o,
               reg_write_o, wb_sel_o, trap_o, trap_cause_o, instret_o, state_o
    );

    modport slave (
        output run_i, opcode_i, funct3_i, mem_ready_i, alu_zero_i,
        input  mem_req_o, mem_we_o, iord_o, ir_write_o, mdr_write_o, rf_latch_o,
               pc_write_o, pc_src_o, alu_src_a_o, alu_src_b_o, alu_op_sel_o,
               reg_write_o, wb_sel_o, trap_o, trap_cause_o, instret_o, state_o
    );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Main sequencer of the multi-cycle RV32I core: steps each instruction through its
// states, drives datapath selects/enables, handshakes with memory and counts retires.
module multicycle_ctrl_fsm #(
    parameter int INSTRET_W   = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input logic                   clk,
    input logic                   rst_n,
    multicycle_ctrl_fsm_if.master bus
);
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MADDR  = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_WBALU  = 4'd7,
        S_WBMEM  = 4'd8,
        S_BRANCH = 4'd9,
        S_TRAP   = 4'd15
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           cause_q, cause_d;
    logic [INSTRET_W-1:0] instret_q, instret_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic                 mem_wait;
    logic                 retire;
    logic                 illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cause_q   <= 2'b00;
            instret_q <= '0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            instret_q <= instret_d;
            wait_q    <= wait_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        instret_d = instret_q;
        retire    = 1'b0;
        illegal   = 1'b0;
        mem_wait  = (state_q == S_FETCH || state_q == S_MEMRD || state_q == S_MEMWR)
                    && !bus.mem_ready_i;

        case (state_q)
            S_IDLE:   if (bus.run_i) state_d = S_FETCH;
            S_FETCH:  if (bus.mem_ready_i) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode_i)
                    OP_LOAD, OP_STORE:  state_d = S_MADDR;
                    OP_IMM, OP_R_TYPE:  state_d = S_EXEC;
                    OP_BRANCH: begin
                        if (bus.funct3_i == 3'b000 || bus.funct3_i == 3'b001)
                            state_d = S_BRANCH;
                        else
                            illegal = 1'b1;
                    end
                    default:            illegal = 1'b1;
                endcase
            end
            S_MADDR: begin
                if (bus.opcode_i == OP_LOAD)
                    state_d = S_MEMRD;
                else if (bus.opcode_i == OP_STORE)
                    state_d = S_MEMWR;
                else
                    illegal = 1'b1;
            end
            S_MEMRD:  if (bus.mem_ready_i) state_d = S_WBMEM;
            S_MEMWR:  if (bus.mem_ready_i) retire = 1'b1;
            S_EXEC:   state_d = S_WBALU;
            S_WBALU, S_WBMEM, S_BRANCH: retire = 1'b1;
            S_TRAP:   state_d = S_TRAP;
            default:  illegal = 1'b1;
        endcase

        if (illegal) begin
            state_d = S_TRAP;
            cause_d = 2'b01;
        end

        // A stalled access that has already waited MEM_TIMEOUT-1 cycles gives up on this edge.
        if (MEM_TIMEOUT != 0 && mem_wait && wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
            state_d = S_TRAP;
            cause_d = 2'b10;
        end

        if (retire) begin
            instret_d = instret_q + INSTRET_W'(1);
            state_d   = bus.run_i ? S_FETCH : S_IDLE;
        end

        wait_d = (MEM_TIMEOUT != 0 && mem_wait && state_d == state_q) ? wait_q + WAIT_W'(1) : '0;
    end

    always_comb begin
        bus.mem_req_o    = 1'b0;
        bus.mem_we_o     = 1'b0;
        bus.iord_o       = 1'b0;
        bus.ir_write_o   = 1'b0;
        bus.mdr_write_o  = 1'b0;
        bus.rf_latch_o   = 1'b0;
        bus.pc_write_o   = 1'b0;
        bus.pc_src_o     = 1'b0;
        bus.alu_src_a_o  = 2'b00;
        bus.alu_src_b_o  = 2'b00;
        bus.alu_op_sel_o = 2'b00;
        bus.reg_write_o  = 1'b0;
        bus.wb_sel_o     = 1'b0;
        bus.trap_o       = 1'b0;
        bus.trap_cause_o = 2'b00;
        bus.instret_o    = instret_q;
        bus.state_o      = state_q;

        case (state_q)
            S_FETCH: begin
                bus.mem_req_o   = 1'b1;
                bus.alu_src_b_o = 2'b01;
                bus.ir_write_o  = bus.mem_ready_i;
                bus.pc_write_o  = bus.mem_ready_i;
            end
            S_DECODE: begin
                bus.rf_latch_o  = 1'b1;
                bus.alu_src_a_o = 2'b01;
                bus.alu_src_b_o = 2'b10;
            end
            S_MADDR: begin
                bus.alu_src_a_o = 2'b10;
                bus.alu_src_b_o = 2'b10;
            end
            S_MEMRD: begin
                bus.mem_req_o   = 1'b1;
                bus.iord_o      = 1'b1;
                bus.mdr_write_o = bus.mem_ready_i;
            end
            S_MEMWR: begin
                bus.mem_req_o = 1'b1;
                bus.mem_we_o  = 1'b1;
                bus.iord_o    = 1'b1;
            end
            S_EXEC: begin
                bus.alu_src_a_o  = 2'b10;
                bus.alu_src_b_o  = (bus.opcode_i == OP_R_TYPE) ? 2'b00 : 2'b10;
                bus.alu_op_sel_o = 2'b10;
            end
            S_WBALU: bus.reg_write_o = 1'b1;
            S_WBMEM: begin
                bus.reg_write_o = 1'b1;
                bus.wb_sel_o    = 1'b1;
            end
            // funct3[0] distinguishes BNE from BEQ, so it inverts the zero-taken sense.
            S_BRANCH: begin
                bus.alu_src_a_o  = 2'b10;
                bus.alu_op_sel_o = 2'b01;
                bus.pc_src_o     = 1'b1;
                bus.pc_write_o   = bus.alu_zero_i ^ bus.funct3_i[0];
            end
            S_TRAP: begin
                bus.trap_o       = 1'b1;
                bus.trap_cause_o = cause_q;
            end
            default: ;
        endcase
    end
endmodule
